// File: rtl/crc8_serial_if.sv
// Byte-in / CRC-out bundle for the bit-serial CRC-8 engine.
// Master offers bytes and clears; slave reports CRC and progress.
interface crc8_serial_if;
  logic       CLR;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       DIN_READY;
  logic [7:0] CRC;
  logic       BUSY;
  logic       DONE;

  modport master (
    output CLR,
    output DIN,
    output DIN_VALID,
    input  DIN_READY,
    input  CRC,
    input  BUSY,
    input  DONE
  );

  modport slave (
    input  CLR,
    input  DIN,
    input  DIN_VALID,
    output DIN_READY,
    output CRC,
    output BUSY,
    output DONE
  );
endinterface

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8, MSB first: one byte per 8 shift cycles.
// Idle cycle between bytes gives 9-cycle peak throughput.
module crc8_serial #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input logic           CLK,
  input logic           RST,
  crc8_serial_if.slave  bus
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t     state;
  logic [7:0] crc_q;
  logic [7:0] data_q;
  logic [2:0] cnt;
  logic       done_q;
  logic       din_ready;
  logic       fb;
  logic [7:0] crc_next;

  assign din_ready     = (state == IDLE) && !bus.CLR;
  assign bus.DIN_READY = din_ready;
  assign bus.CRC       = crc_q;
  assign bus.BUSY      = (state == SHIFT);
  assign bus.DONE      = done_q;

  // One LFSR step folding in the current data MSB.
  always_comb begin
    fb       = crc_q[7] ^ data_q[7];
    crc_next = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  end

  // FSM, CRC register, data shifter and DONE pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      crc_q  <= INIT;
      data_q <= 8'h00;
      cnt    <= 3'd0;
      done_q <= 1'b0;
    end else if (bus.CLR) begin
      state  <= IDLE;
      crc_q  <= INIT;
      cnt    <= 3'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.DIN_VALID && din_ready) begin
            data_q <= bus.DIN;
            cnt    <= 3'd0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          crc_q  <= crc_next;
          data_q <= {data_q[6:0], 1'b0};
          if (cnt == 3'd7) begin
            cnt    <= 3'd0;
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/crc8_serial.md
CRC8_SERIAL -- requirements
Module: crc8_serial

Interface
REQ-001 The block SHALL have parameter POLY, default 8'h07, meaning the CRC generator polynomial with the implicit x^8 term omitted.
REQ-002 The block SHALL have parameter INIT, default 8'h00, meaning the CRC register value loaded at reset and on CLR.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port CLR, input, 1 bit: synchronous reload of CRC to INIT and abort of any byte in progress.
REQ-006 The block SHALL have port DIN, input, 8 bits: the data byte, consumed MSB first.
REQ-007 The block SHALL have port DIN_VALID, input, 1 bit: DIN holds a byte offered for acceptance.
REQ-008 The block SHALL have port DIN_READY, output, 1 bit: the block can accept a byte this cycle.
REQ-009 The block SHALL have port CRC, output, 8 bits: the running CRC register, driven directly from the register.
REQ-010 The block SHALL have port BUSY, output, 1 bit: a byte is being shifted.
REQ-011 The block SHALL have port DONE, output, 1 bit: a one-cycle pulse marking that a byte has completed.

Function
REQ-012 The block SHALL implement a two-state FSM with states IDLE and SHIFT, a 3-bit bit counter, and an 8-bit data shift register.
REQ-013 The block SHALL drive DIN_READY = (state==IDLE) && !CLR combinationally, and BUSY = (state==SHIFT).
REQ-014 In IDLE, when DIN_VALID && DIN_READY at a clock edge, the block SHALL load DIN into the data register, clear the bit counter, and enter SHIFT.
REQ-015 In SHIFT, on each edge the block SHALL compute fb = CRC[7] ^ data[7].
REQ-016 In SHIFT, on each edge CRC SHALL become {CRC[6:0],1'b0} ^ (fb ? POLY : 8'h00).
REQ-017 In SHIFT, on each edge the data register SHALL shift left by one and the bit counter SHALL increment.
REQ-018 On the SHIFT edge where the bit counter equals 7, the block SHALL perform the final bit update and return to IDLE.
REQ-019 DONE SHALL be registered and be high for exactly the one cycle following that final-bit edge; DONE SHALL be low in all other cycles.
REQ-020 Latency: for a byte accepted at edge k, CRC SHALL be final after edge k+8, and DONE and DIN_READY SHALL be high in the cycle after edge k+8.
REQ-021 Peak throughput SHALL be one byte per 9 cycles.
REQ-022 A byte offered back-to-back SHALL be accepted at edge k+9.
REQ-023 DIN and DIN_VALID SHALL be ignored while in SHIFT; DIN need not be held stable after acceptance.
REQ-024 CLR SHALL have priority over all FSM activity in every state: CRC SHALL load INIT, the state SHALL go to IDLE, the bit counter SHALL clear, DONE SHALL be 0 next cycle, and no byte SHALL be accepted that cycle.
REQ-025 A CLR during SHIFT SHALL discard the partial byte without a DONE pulse.
REQ-026 In IDLE without CLR or accept, CRC SHALL hold its value, so successive bytes accumulate.
REQ-027 The bit counter SHALL wrap from 7 to 0 only via the IDLE transition and SHALL never exceed 7.

Reset
REQ-028 When RST is high at a clock edge, the block SHALL force state=IDLE, CRC=INIT, bit counter=0, data register=0, and DONE=0; RST SHALL take priority over CLR and DIN_VALID.
REQ-029 While RST is high, the outputs SHALL read DIN_READY per REQ-013 after the first reset edge, BUSY=0, and DONE=0.
REQ-030 A RST during SHIFT SHALL abort the byte with no DONE pulse.

Verification
REQ-031 With defaults and RST pulsed, offering DIN=8'h01 SHALL give CRC=8'h07 and DONE high in the cycle after the 8th shift edge; BUSY SHALL be high for exactly 8 cycles.
REQ-032 After reset, offering DIN=8'h80 SHALL step CRC through 07,0E,1C,38,70,E0,C7,89 on successive edges, ending at 8'h89.
REQ-033 Streaming 8'h31..8'h39 ("123456789") back-to-back with DIN_VALID held high SHALL accept each byte every 9 cycles and leave a final CRC of 8'hF4.
REQ-034 Asserting CLR on the 4th SHIFT cycle of a byte SHALL give CRC=8'h00, state IDLE, and no DONE; with CLR and DIN_VALID high together, DIN_READY SHALL be 0 and the byte SHALL not be accepted.
REQ-035 Asserting RST mid-byte together with CLR and DIN_VALID SHALL give, next cycle, BUSY=0, DONE=0, CRC=INIT; with INIT=8'hFF overridden, the reset value of CRC SHALL be 8'hFF.
